// File: rtl/seq_det_pkg.sv
// Shared mode encodings and width helpers for the parametrised sequence detector.
package seq_det_pkg;

   localparam logic [1:0] MODE_STICKY  = 2'b00;
   localparam logic [1:0] MODE_OVERLAP = 2'b01;
   localparam logic [1:0] MODE_NONOVL  = 2'b10;

   // Width needed to hold a matched-prefix length of 0..len.
   function automatic int unsigned st_width(input int unsigned len);
      return $clog2(len + 1);
   endfunction

   // Encoding 2'b11 behaves as sticky.
   function automatic logic is_sticky(input logic [1:0] mode);
      return (mode == MODE_STICKY) || (mode == 2'b11);
   endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational fallback search: longest pattern prefix that is a suffix of the
// shifted history, bounded by the current matched length plus one.
module seq_det_next_state
   import seq_det_pkg::*;
#(
   parameter int unsigned PATTERN_LEN = 7,
   parameter int unsigned ST_W        = st_width(PATTERN_LEN)
) (
   input  logic [PATTERN_LEN-1:0] pat_i,
   input  logic [PATTERN_LEN-1:0] hist_i,
   input  logic [ST_W-1:0]        state_i,
   input  logic                   x_i,
   input  logic [1:0]             mode_i,
   output logic [ST_W-1:0]        next_state_c_o,
   output logic                   match_c_o
);

   localparam logic [ST_W-1:0] FULL = ST_W'(PATTERN_LEN);

   logic [PATTERN_LEN-1:0] h_c;
   logic [PATTERN_LEN-1:0] mask_c;
   logic [ST_W-1:0]        p_c;
   int unsigned            p_lim_c;
   int unsigned            best_c;
   logic                   unused_hist_msb;

   // The oldest history bit drops out of every window of length <= PATTERN_LEN.
   assign unused_hist_msb = hist_i[PATTERN_LEN-1];

   always_comb begin
      h_c     = {hist_i[PATTERN_LEN-2:0], x_i};
      p_c     = state_i;
      mask_c  = '0;
      best_c  = 0;
      if ((mode_i == MODE_NONOVL) && (state_i == FULL)) begin
         p_c = '0;
      end
      p_lim_c = 32'(p_c) + 32'd1;
      // Compare pat[LEN-1 -: k] against h'[k-1:0] by aligning the prefix to bit 0.
      for (int unsigned k = 1; k <= PATTERN_LEN; k++) begin
         mask_c = {PATTERN_LEN{1'b1}} >> (PATTERN_LEN - k);
         if ((k <= p_lim_c) && ((((pat_i >> (PATTERN_LEN - k)) ^ h_c) & mask_c) == '0)) begin
            best_c = k;
         end
      end
      next_state_c_o = ST_W'(best_c);
      match_c_o      = (best_c == PATTERN_LEN);
   end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern and sticky/overlap/non-overlap modes.
// Define MATCH_CNT_EN to add the saturating match_count output.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int unsigned             PATTERN_LEN = 7,
   parameter logic [PATTERN_LEN-1:0]  PATTERN     = 7'b0110111,
   parameter int unsigned             CNT_W       = 8,
   localparam int unsigned            ST_W        = st_width(PATTERN_LEN)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   x,
   input  logic                   x_valid,
   input  logic [1:0]             mode,
   input  logic                   load,
   input  logic [PATTERN_LEN-1:0] pattern_in,
   output logic [ST_W-1:0]        state,
   output logic                   match,
   output logic                   locked
`ifdef MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0]       match_count
`endif
);

   localparam logic [ST_W-1:0] FULL = ST_W'(PATTERN_LEN);

   logic [PATTERN_LEN-1:0] pat_q, pat_d;
   logic [PATTERN_LEN-1:0] hist_q, hist_d;
   logic [ST_W-1:0]        state_q, state_d;
   logic                   match_q, match_d;
   logic                   locked_q, locked_d;
   logic [ST_W-1:0]        next_state_c;
   logic                   match_c;
   logic                   sticky_c;
   logic                   hold_c;

   seq_det_next_state #(
      .PATTERN_LEN (PATTERN_LEN),
      .ST_W        (ST_W)
   ) u_next (
      .pat_i          (pat_q),
      .hist_i         (hist_q),
      .state_i        (state_q),
      .x_i            (x),
      .mode_i         (mode),
      .next_state_c_o (next_state_c),
      .match_c_o      (match_c)
   );

   assign sticky_c = is_sticky(mode);
   assign hold_c   = sticky_c && (state_q == FULL);

   // Load wins over sampling; a locked sticky detector ignores further samples.
   always_comb begin
      pat_d    = pat_q;
      hist_d   = hist_q;
      state_d  = state_q;
      match_d  = 1'b0;
      locked_d = locked_q;
      if (load) begin
         pat_d    = pattern_in;
         hist_d   = '0;
         state_d  = '0;
         locked_d = 1'b0;
      end else if (x_valid && !hold_c) begin
         hist_d   = {hist_q[PATTERN_LEN-2:0], x};
         state_d  = next_state_c;
         match_d  = match_c;
         locked_d = sticky_c && match_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q    <= PATTERN;
         hist_q   <= '0;
         state_q  <= '0;
         match_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         pat_q    <= pat_d;
         hist_q   <= hist_d;
         state_q  <= state_d;
         match_q  <= match_d;
         locked_q <= locked_d;
      end
   end

   assign state  = state_q;
   assign match  = match_q;
   assign locked = locked_q;

`ifdef MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts alongside the match pulse it accompanies, saturating at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (match_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_count = cnt_q;
`else
   localparam logic [CNT_W-1:0] unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: a default 7-bit detector and a 3-bit detector driven side by side.
module tb_seq_detector_param;
   import seq_det_pkg::*;

   logic       clk;
   logic       rst7, x7, xv7, load7;
   logic [1:0] mode7;
   logic [6:0] pin7;
   logic [2:0] st7;
   logic       m7, l7;
   logic       rst3, x3, xv3, load3;
   logic [1:0] mode3;
   logic [2:0] pin3;
   logic [1:0] st3;
   logic       m3, l3;
`ifdef MATCH_CNT_EN
   logic [7:0] cnt7;
   logic [1:0] cnt3;
`endif

   int checks = 0;
   int errors = 0;

   seq_detector_param u7 (
      .clk (clk), .reset (rst7), .x (x7), .x_valid (xv7), .mode (mode7),
      .load (load7), .pattern_in (pin7), .state (st7), .match (m7), .locked (l7)
`ifdef MATCH_CNT_EN
      , .match_count (cnt7)
`endif
   );

   seq_detector_param #(.PATTERN_LEN(3), .PATTERN(3'b000), .CNT_W(2)) u3 (
      .clk (clk), .reset (rst3), .x (x3), .x_valid (xv3), .mode (mode3),
      .load (load3), .pattern_in (pin3), .state (st3), .match (m3), .locked (l3)
`ifdef MATCH_CNT_EN
      , .match_count (cnt3)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic s7(input logic b);
      x7 = b; xv7 = 1'b1;
      @(posedge clk); #1;
      xv7 = 1'b0;
   endtask

   task automatic s3(input logic b);
      x3 = b; xv3 = 1'b1;
      @(posedge clk); #1;
      xv3 = 1'b0;
   endtask

   task automatic ld7(input logic [6:0] p);
      load7 = 1'b1; pin7 = p;
      @(posedge clk); #1;
      load7 = 1'b0;
   endtask

   task automatic ld3(input logic [2:0] p);
      load3 = 1'b1; pin3 = p;
      @(posedge clk); #1;
      load3 = 1'b0;
   endtask

   initial begin
      logic [6:0] seq7;
      logic [3:0] tail7;
      logic [5:0] pre7;
      logic [4:0] seq3;
      int         exp_ov[5];
      int         exp_no[5];
      clk = 1'b0;
      rst7 = 1'b1; x7 = 1'b0; xv7 = 1'b0; load7 = 1'b0; mode7 = MODE_STICKY; pin7 = '0;
      rst3 = 1'b1; x3 = 1'b0; xv3 = 1'b0; load3 = 1'b0; mode3 = MODE_OVERLAP; pin3 = '0;
      #2;
      chk("reset_state7", 32'(st7), 0);
      chk("reset_match7", 32'(m7), 0);
      chk("reset_locked7", 32'(l7), 0);
      chk("reset_state3", 32'(st3), 0);
      #10;
      rst7 = 1'b0; rst3 = 1'b0;
      @(posedge clk); #1;

      // Default pattern, sticky: match at the 7th bit then hold locked.
      seq7 = 7'b0110111;
      for (int i = 6; i >= 0; i--) begin
         s7(seq7[i]);
         chk("sticky_state", 32'(st7), 32'(7 - i));
         chk("sticky_match", 32'(m7), (i == 0) ? 32'd1 : 32'd0);
      end
      chk("sticky_locked", 32'(l7), 1);
      @(posedge clk); #1;
      chk("idle_match", 32'(m7), 0);
      chk("idle_state", 32'(st7), 7);
      tail7 = 4'b0101;
      for (int i = 3; i >= 0; i--) begin
         s7(tail7[i]);
         chk("locked_hold_state", 32'(st7), 7);
         chk("locked_hold_match", 32'(m7), 0);
         chk("locked_hold_lock", 32'(l7), 1);
      end

      // Leaving sticky: locked clears and the sample uses overlap rules.
      mode7 = MODE_OVERLAP;
      s7(1'b0);
      chk("unlock_state", 32'(st7), 1);
      chk("unlock_locked", 32'(l7), 0);
      chk("unlock_match", 32'(m7), 0);

      // Fallback from 6: 0110110 ends in prefix 0110.
      mode7 = MODE_STICKY;
      ld7(7'b0110111);
      chk("load_state", 32'(st7), 0);
      chk("load_locked", 32'(l7), 0);
      pre7 = 6'b011011;
      for (int i = 5; i >= 0; i--) s7(pre7[i]);
      chk("pre_fallback_state", 32'(st7), 6);
      s7(1'b0);
      chk("fallback_state", 32'(st7), 4);
      chk("fallback_match", 32'(m7), 0);

      // Load together with x_valid at state 5: sample discarded.
      ld7(7'b0110111);
      for (int i = 6; i >= 2; i--) s7(seq7[i]);
      chk("pre_load_state", 32'(st7), 5);
      load7 = 1'b1; pin7 = 7'b0110111; x7 = 1'b1; xv7 = 1'b1;
      @(posedge clk); #1;
      load7 = 1'b0; xv7 = 1'b0;
      chk("load_valid_state", 32'(st7), 0);
      chk("load_valid_match", 32'(m7), 0);
`ifdef MATCH_CNT_EN
      chk("load_valid_count", 32'(cnt7), 0);
`endif
      s7(1'b0);
      chk("after_load_state", 32'(st7), 1);

      // 3-bit detector, pattern 101, overlap then non-overlap.
      seq3 = 5'b10101;
      exp_ov = '{1, 2, 3, 2, 3};
      exp_no = '{1, 2, 3, 0, 1};
      mode3 = MODE_OVERLAP;
      ld3(3'b101);
      for (int i = 0; i < 5; i++) begin
         s3(seq3[4 - i]);
         chk("ovl_state", 32'(st3), 32'(exp_ov[i]));
         chk("ovl_match", 32'(m3), (i == 2 || i == 4) ? 32'd1 : 32'd0);
      end
      mode3 = MODE_NONOVL;
      ld3(3'b101);
      for (int i = 0; i < 5; i++) begin
         s3(seq3[4 - i]);
         chk("nonovl_state", 32'(st3), 32'(exp_no[i]));
         chk("nonovl_match", 32'(m3), (i == 2) ? 32'd1 : 32'd0);
      end

      // Six overlapping matches; the 2-bit counter saturates at 3.
      mode3 = MODE_OVERLAP;
      ld3(3'b101);
      s3(1'b1);
      for (int i = 0; i < 6; i++) begin
         s3(1'b0);
         s3(1'b1);
         chk("rep_match", 32'(m3), 1);
`ifdef MATCH_CNT_EN
         chk("rep_count", 32'(cnt3), (i < 3) ? 32'(i + 1) : 32'd3);
`endif
      end
      chk("rep_state", 32'(st3), 3);

      // Asynchronous reset between edges clears outputs at once.
      #3;
      rst3 = 1'b1;
      #1;
      chk("async_state", 32'(st3), 0);
      chk("async_match", 32'(m3), 0);
`ifdef MATCH_CNT_EN
      chk("async_count", 32'(cnt3), 0);
`endif
      #2;
      rst3 = 1'b0;
      @(posedge clk); #1;
      // Reset pattern is 000, so a 0 now advances where 101 would not.
      s3(1'b0);
      chk("restart_state", 32'(st3), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
